param_frame_parser: RTL and testbench

//   Turns the host byte stream from the UART receiver into single-cycle parameter writes for the parameter demux.

---
 rtl/param_frame_parser.sv | 161 ++++++++++++++++
 tb/tb_param_frame_parser.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_frame_parser.sv
// Host frame parser: SYNC, HDR, VAL_HI, VAL_LO, CHK -> one-cycle parameter write.
// Rejects frames with a bad header, a bad XOR checksum, or an inter-byte timeout.
module param_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [2:0]  o_param_addr,
  output logic [15:0] o_param_value,
  output logic        o_param_valid,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_VHI,
    S_VLO,
    S_CHK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_acc;
  logic [7:0]       r_hdr;
  logic [7:0]       r_vhi;
  logic [7:0]       r_vlo;
  logic [2:0]       r_param_addr;
  logic [15:0]      r_param_value;
  logic             r_param_valid;
  logic             r_frame_err;
  logic [1:0]       r_err_code;
  logic [7:0]       r_err_count;

  logic       w_timeout;
  logic       w_chk_byte;
  logic       w_hdr_bad;
  logic       w_sum_bad;
  logic       w_accept;
  logic       w_reject;
  logic [1:0] w_rej_code;

  // A byte arriving on the limit cycle clears the condition, so the byte wins.
  assign w_timeout  = (r_state != S_IDLE) && !i_rx_valid && (r_cnt == CNT_LIMIT);
  assign w_chk_byte = (r_state == S_CHK) && i_rx_valid;
  assign w_hdr_bad  = |r_hdr[7:3];
  assign w_sum_bad  = (i_rx_data != r_acc);
  assign w_accept   = w_chk_byte && !w_hdr_bad && !w_sum_bad;
  assign w_reject   = w_timeout || (w_chk_byte && (w_hdr_bad || w_sum_bad));

  always_comb begin
    w_rej_code = 2'd0;
    if (w_timeout)      w_rej_code = 2'd3;
    else if (w_hdr_bad) w_rej_code = 2'd2;
    else                w_rej_code = 2'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (i_rx_valid) begin
      case (r_state)
        S_IDLE:  if (i_rx_data == SYNC_BYTE) w_state_next = S_HDR;
        S_HDR:   w_state_next = S_VHI;
        S_VHI:   w_state_next = S_VLO;
        S_VLO:   w_state_next = S_CHK;
        S_CHK:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || i_rx_valid || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 8'h00;
      r_hdr <= 8'h00;
      r_vhi <= 8'h00;
      r_vlo <= 8'h00;
    end else if (i_rx_valid) begin
      case (r_state)
        S_IDLE: if (i_rx_data == SYNC_BYTE) r_acc <= 8'h00;
        S_HDR: begin
          r_hdr <= i_rx_data;
          r_acc <= r_acc ^ i_rx_data;
        end
        S_VHI: begin
          r_vhi <= i_rx_data;
          r_acc <= r_acc ^ i_rx_data;
        end
        S_VLO: begin
          r_vlo <= i_rx_data;
          r_acc <= r_acc ^ i_rx_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_param_addr  <= 3'd0;
      r_param_value <= 16'h0000;
      r_param_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= 2'd0;
      r_err_count   <= 8'd0;
    end else begin
      r_param_valid <= w_accept;
      r_frame_err   <= w_reject;
      if (w_accept) begin
        r_param_addr  <= r_hdr[2:0];
        r_param_value <= {r_vhi, r_vlo};
      end
      if (w_reject) begin
        r_err_code <= w_rej_code;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_param_addr  = r_param_addr;
  assign o_param_value = r_param_value;
  assign o_param_valid = r_param_valid;
  assign o_frame_err   = r_frame_err;
  assign o_err_code    = r_err_code;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_param_frame_parser.sv
// Bench for param_frame_parser: directed frame table, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_param_frame_parser;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [2:0]  o_param_addr;
  logic [15:0] o_param_value;
  logic        o_param_valid;
  logic        o_frame_err;
  logic [1:0]  o_err_code;
  logic [7:0]  o_err_count;
  logic        o_busy;

  param_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_param_addr (o_param_addr),
    .o_param_value(o_param_value),
    .o_param_valid(o_param_valid),
    .o_frame_err  (o_frame_err),
    .o_err_code   (o_err_code),
    .o_err_count  (o_err_count),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] bytes;
    logic        ok;
    logic [2:0]  addr;
    logic [15:0] val;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  logic [2:0]  m_addr;
  logic [15:0] m_val;
  logic [1:0]  m_code;
  int          m_cnt;
  int          m_acc_n = 0;
  int          m_rej_n = 0;
  int          pv_seen = 0;
  int          fe_seen = 0;

  always @(negedge clk) begin
    if (o_param_valid) pv_seen++;
    if (o_frame_err) fe_seen++;
    checks++;
    if (o_param_valid && o_frame_err) begin
      errors++;
      $display("FAIL both_strobes: param_valid=%0b frame_err=%0b required not both 1",
               o_param_valid, o_frame_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic model_reject(input logic [1:0] code);
    m_code = code;
    if (m_cnt < 255) m_cnt++;
    m_rej_n++;
  endtask

  task automatic model_accept(input logic [2:0] a, input logic [15:0] v);
    m_addr = a;
    m_val  = v;
    m_acc_n++;
  endtask

  task automatic model_frame(input logic [39:0] f, output logic ok);
    logic [7:0] h, vh, vl, c;
    h  = f[31:24];
    vh = f[23:16];
    vl = f[15:8];
    c  = f[7:0];
    ok = 1'b0;
    if (h[7:3] != 5'd0)       model_reject(2'd2);
    else if (c != (h ^ vh ^ vl)) model_reject(2'd1);
    else begin
      ok = 1'b1;
      model_accept(h[2:0], {vh, vl});
    end
  endtask

  task automatic check_state(input string tag, input logic exp_pv, input logic exp_fe,
                             input logic exp_busy);
    chk({tag, ".param_valid"}, 32'(o_param_valid), 32'(exp_pv));
    chk({tag, ".frame_err"},   32'(o_frame_err),   32'(exp_fe));
    chk({tag, ".param_addr"},  32'(o_param_addr),  32'(m_addr));
    chk({tag, ".param_value"}, 32'(o_param_value), 32'(m_val));
    chk({tag, ".err_code"},    32'(o_err_code),    32'(m_code));
    chk({tag, ".err_count"},   32'(o_err_count),   32'(m_cnt));
    chk({tag, ".busy"},        32'(o_busy),        32'(exp_busy));
  endtask

  // Sends five bytes; each in-frame gap is drawn from 0..maxgap idle cycles (maxgap < TO)
  task automatic send_frame_raw(input logic [39:0] f, input int maxgap);
    for (int i = 0; i < 5; i++) begin
      send_byte(f[39-8*i -: 8]);
      if (i < 4) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic send_timeout(input logic [39:0] f, input int nbytes, input string tag);
    for (int i = 0; i < nbytes; i++) send_byte(f[39-8*i -: 8]);
    idle(TO - 1);
    check_state({tag, ".pre"}, 1'b0, 1'b0, 1'b1);
    idle(1);
    model_reject(2'd3);
    check_state(tag, 1'b0, 1'b1, 1'b0);
    $display("timeout frame %h after %0d bytes: code=%0d count=%0d", f, nbytes, o_err_code,
             o_err_count);
  endtask

  initial begin
    logic        ok;
    logic [39:0] f;
    logic [7:0]  h, vh, vl, c, b;
    int          base_pv, base_fe;

    tbl[0] = '{40'hA5_02_04_00_06, 1'b1, 3'd2, 16'h0400, 2'd0};
    tbl[1] = '{40'hA5_04_10_00_FF, 1'b0, 3'd0, 16'h0000, 2'd1};
    tbl[2] = '{40'hA5_04_10_00_14, 1'b1, 3'd4, 16'h1000, 2'd0};
    tbl[3] = '{40'hA5_0A_00_01_0B, 1'b0, 3'd0, 16'h0000, 2'd2};
    tbl[4] = '{40'hA5_07_A5_A5_07, 1'b1, 3'd7, 16'hA5A5, 2'd0};
    tbl[5] = '{40'hA5_F8_00_00_00, 1'b0, 3'd0, 16'h0000, 2'd2};
    tbl[6] = '{40'hA5_00_FF_FF_00, 1'b1, 3'd0, 16'hFFFF, 2'd0};
    tbl[7] = '{40'hA5_05_12_34_23, 1'b1, 3'd5, 16'h1234, 2'd0};

    m_addr = 3'd0; m_val = 16'h0; m_code = 2'd0; m_cnt = 0;
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    idle(3);
    check_state("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    check_state("post_reset", 1'b0, 1'b0, 1'b0);

    // Directed table; expectations come from the table rows
    for (int i = 0; i < 8; i++) begin
      send_frame_raw(tbl[i].bytes, i % 3);
      if (tbl[i].ok) model_accept(tbl[i].addr, tbl[i].val);
      else           model_reject(tbl[i].code);
      check_state($sformatf("tbl%0d", i), tbl[i].ok, !tbl[i].ok, 1'b0);
      $display("table frame %0d %h: valid=%0b err=%0b addr=%0d value=%h code=%0d count=%0d",
               i, tbl[i].bytes, o_param_valid, o_frame_err, o_param_addr, o_param_value,
               o_err_code, o_err_count);
      idle(1);
      check_state($sformatf("tbl%0d.after", i), 1'b0, 1'b0, 1'b0);
    end

    // Idle noise produces nothing
    base_pv = pv_seen;
    base_fe = fe_seen;
    send_byte(8'h00); chk("noise00.busy", 32'(o_busy), 0);
    send_byte(8'hFF); chk("noiseFF.busy", 32'(o_busy), 0);
    send_byte(8'h5A); chk("noise5A.busy", 32'(o_busy), 0);
    idle(2);
    chk("noise.writes", pv_seen, base_pv);
    chk("noise.errs", fe_seen, base_fe);
    check_state("noise", 1'b0, 1'b0, 1'b0);
    $display("idle noise 00 FF 5A: writes=%0d errs=%0d", pv_seen - base_pv, fe_seen - base_fe);

    // Timeout after A5 01 and 16 idle cycles
    send_timeout(40'hA5_01_00_00_00, 2, "timeout");
    idle(1);
    // Byte on the limit cycle is consumed, then the frame completes
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TO - 1);
    send_byte(8'h12);
    check_state("limit_byte", 1'b0, 1'b0, 1'b1);
    send_byte(8'h34);
    send_byte(8'h27);
    model_accept(3'd1, 16'h1234);
    check_state("after_limit", 1'b1, 1'b0, 1'b0);
    $display("limit-cycle frame A5 01 12 34 27: valid=%0b addr=%0d value=%h",
             o_param_valid, o_param_addr, o_param_value);

    // Back-to-back frames, no dead cycle
    send_frame_raw(40'hA5_03_AA_55_FC, 0);
    model_accept(3'd3, 16'hAA55);
    check_state("b2b0", 1'b1, 1'b0, 1'b0);
    send_frame_raw(40'hA5_06_01_02_00, 0);
    model_reject(2'd1);
    check_state("b2b1", 1'b0, 1'b1, 1'b0);
    $display("back-to-back frames: code=%0d count=%0d", o_err_code, o_err_count);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h03);
    rst = 1'b1;
    idle(1);
    m_addr = 3'd0; m_val = 16'h0; m_code = 2'd0; m_cnt = 0;
    check_state("mid_reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    send_frame_raw(40'hA5_03_12_34_25, 1);
    model_accept(3'd3, 16'h1234);
    check_state("post_mid_reset", 1'b1, 1'b0, 1'b0);
    $display("frame after mid-frame reset: valid=%0b addr=%0d value=%h",
             o_param_valid, o_param_addr, o_param_value);

    // Random frames against the frame-level model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
        check_state($sformatf("rnd%0d.noise", n), 1'b0, 1'b0, 1'b0);
      end
      h  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {5'd0, 3'($urandom)};
      vh = 8'($urandom);
      vl = 8'($urandom);
      c  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (h ^ vh ^ vl);
      f  = {8'hA5, h, vh, vl, c};
      if ($urandom_range(0, 9) == 0) begin
        send_timeout(f, $urandom_range(1, 4), $sformatf("rnd%0d.to", n));
      end else begin
        send_frame_raw(f, ($urandom_range(0, 4) == 0) ? TO - 1 : 2);
        model_frame(f, ok);
        check_state($sformatf("rnd%0d", n), ok, !ok, 1'b0);
        $display("random frame %0d %h: valid=%0b err=%0b code=%0d count=%0d",
                 n, f, o_param_valid, o_frame_err, o_err_code, o_err_count);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end

    // Saturation of the error counter
    for (int n = 0; n < 260; n++) begin
      send_frame_raw(40'hA5_00_00_00_01, 0);
      model_reject(2'd1);
      check_state($sformatf("sat%0d", n), 1'b0, 1'b1, 1'b0);
      $display("saturation frame %0d: err_count=%0d", n, o_err_count);
    end
    chk("sat.final", 32'(o_err_count), 32'd255);

    idle(3);
    chk("total_writes", pv_seen, m_acc_n);
    chk("total_errs", fe_seen, m_rej_n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
